// File: rtl/gf_mul_array.sv
// gf_mul_array: multi-lane iterative GF(2^8) multiplier, BPC multiplier bits
// per cycle, MSB-first Horner evaluation, valid/ready on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block can accept operands (follows out_ready while in DONE)
//   op1        multiplier bytes,   lane i = op1[8i+7:8i]
//   op2        multiplicand bytes, lane i = op2[8i+7:8i]
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     lane i = op1_i * op2_i mod x^8 + POLY (registered)

module gf_mul_array #(
    parameter int unsigned LANES = 4,
    parameter int unsigned BPC   = 1,
    parameter logic [7:0]  POLY  = 8'h1b
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] op1,
    input  logic [8*LANES-1:0] op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] result
);

    localparam int unsigned STEPS = 8 / BPC;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
        $error("gf_mul_array: BPC must be 1, 2, 4 or 8");
    end

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("gf_mul_array: LANES must be 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_cnt;

    logic [LANES-1:0][7:0] r_m;
    logic [LANES-1:0][7:0] r_b;
    logic [LANES-1:0][7:0] r_a;

    logic [LANES-1:0][7:0] w_a_nxt;
    logic [LANES-1:0][7:0] w_m_nxt;
    logic [7:0]            w_a;
    logic [7:0]            w_m;

    logic w_load;
    logic w_step;
    logic w_last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    // BPC Horner sub-steps chained in one cycle; M is consumed MSB first.
    always_comb begin
        w_a     = '0;
        w_m     = '0;
        w_a_nxt = '0;
        w_m_nxt = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_a = r_a[l];
            w_m = r_m[l];
            for (int k = 0; k < int'(BPC); k++) begin
                w_a = xtime(w_a) ^ (w_m[7] ? r_b[l] : 8'h00);
                w_m = {w_m[6:0], 1'b0};
            end
            w_a_nxt[l] = w_a;
            w_m_nxt[l] = w_m;
        end
    end

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Accepting in DONE removes the IDLE bubble.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_CALC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_b     <= '0;
            r_a     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_m   <= op1;
                r_b   <= op2;
                r_a   <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_a   <= w_a_nxt;
                r_m   <= w_m_nxt;
                // Wrap explicitly so STEPS=1 never leaves cnt off zero.
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign result = r_a;

endmodule

// File: doc/gf_mul_array.md
# gf_mul_array

Multi-lane, iterative GF(2^8) multiplier for the AES datapath, successor to the fixed-constant combinational multiplier. It multiplies LANES independent byte pairs by arbitrary 8-bit operands, not only the MixColumns constants 2/3/9/11/13/14. It processes BPC bits of each multiplier byte per cycle, trading latency for area. It sits between the round-key/state registers and the MixColumns/InvMixColumns and key-expansion logic, with valid/ready handshakes on both sides.

## Interface
Parameters:
- LANES, 4: number of independent byte multipliers (1..16).
- BPC, 1: multiplier bits consumed per cycle; must be 1, 2, 4 or 8, otherwise elaboration fails.
- POLY, 8'h1b: reduction polynomial low byte; the implied x^8 term is fixed.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- op1  in  8*LANES  multiplier bytes; lane i = op1[8i+7:8i].
- op2  in  8*LANES  multiplicand bytes; lane i = op2[8i+7:8i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  8*LANES  lane i = op1_i ⊗ op2_i in GF(2^8) mod x^8+POLY.

## Operation
- Per-lane state: shift register M (copy of op1_i), register B (op2_i), accumulator A.
- Shared state: FSM and step counter cnt, 0..STEPS-1, where STEPS = 8/BPC.
- xtime(a) = (a<<1)[7:0] ^ (a[7] ? POLY : 0).
- Horner step for each of BPC bits, MSB first: A = xtime(A) ^ (M[7] ? B : 0), then M <<= 1. All BPC sub-steps are chained combinationally within one cycle.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, load M=op1, B=op2, A=0, cnt=0, and go to CALC.
  - CALC: in_ready=0, out_valid=0. Apply one BPC-bit step per cycle and increment cnt. On the step where cnt==STEPS-1, go to DONE.
  - DONE: out_valid=1, result=A (registered, stable). in_ready = out_ready.
    - out_ready && in_valid: result is consumed and new operands are loaded in the same edge; go to CALC.
    - out_ready && !in_valid: go to IDLE.
    - !out_ready: hold, and all outputs remain unchanged.
- The lanes share control and always complete together.
- Operands are sampled only at the handshake edge. Later changes to op1/op2 do not affect an operation in progress.
- Edge cases: op1=0 or op2=0 gives 0; op1=1 gives op2. No exceptions or overflow exist because the arithmetic is closed in 8 bits.

## Timing
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, result=0, cnt=0, A/M/B=0.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. The result is lost and no out_valid pulse occurs after release.
- Latency: operands accepted at edge T give out_valid high after edge T+STEPS (BPC=1: 8 cycles; BPC=2: 4; BPC=4: 2; BPC=8: 1).
- Throughput with out_ready held high: one operation per STEPS+1 cycles. The accept in DONE removes the IDLE bubble, so for BPC=8 this is one result every 2 cycles.
- in_ready depends combinationally on out_ready only in DONE. No other combinational input-to-output paths exist.
- in_valid while not in_ready is ignored. The source must hold its data until the handshake.

## Test plan
- Reset then single op, LANES=4, BPC=1: op1=02_01_83_02, op2=87_5a_57_00. Required: out_valid exactly 8 cycles after accept, result=15_5a_c1_00.
- Sweep BPC=1/2/4/8 with op1=0x57, op2=0x13, then 0x0e⊗0x0e. Required: 0xfe and 0x54; latencies 8/4/2/1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: result stable, out_valid stays 1, in_ready=0, a new in_valid is not accepted. Release produces exactly one transfer.
- Back-to-back: in_valid and out_ready tied high, BPC=1, 10 random operand sets. Required: results match a software GF model in order, spaced 9 cycles apart.
- Reset mid-operation: assert rst_n=0 at cnt=3. Required: outputs return to reset values asynchronously, no stale out_valid after release, and the next op computes correctly.
- Exhaustive, LANES=1, BPC=4: all 65536 (op1, op2) pairs against a reference model, including the 0 and 1 identities.
